// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, each with a one-entry result buffer.
// Latency: request granted in cycle T, result valid in T+1; one operation per cycle in total.
// Backpressure: a full buffer with resp ready low blocks its port; drain and refill can share a cycle.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_sel,
    input  logic              req0_ext,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_sel,
    input  logic              req1_ext,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_y,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_y,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    output logic              alu_ext,
    input  logic [DATA_W-1:0] alu_y,

    output logic [CNT_W-1:0]  op_count
);

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic last;

    // A buffer can take a new result when empty or being drained this same cycle.
    assign elig0 = rst_n && req0_valid && (!resp0_valid || resp0_ready);
    assign elig1 = rst_n && req1_valid && (!resp1_valid || resp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = last;
            grant1 = !last;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 3'd0;
        alu_ext = 1'b0;
        if (grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_sel = req0_sel;
            alu_ext = req0_ext;
        end else if (grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sel = req1_sel;
            alu_ext = req1_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_y     <= '0;
            resp1_y     <= '0;
            op_count    <= '0;
            last        <= 1'b1;
        end else begin
            if (grant0) begin
                resp0_y     <= alu_y;
                resp0_valid <= 1'b1;
            end else if (resp0_ready) begin
                resp0_valid <= 1'b0;
            end

            if (grant1) begin
                resp1_y     <= alu_y;
                resp1_valid <= 1'b1;
            end else if (resp1_ready) begin
                resp1_valid <= 1'b0;
            end

            if (grant0 || grant1) begin
                last     <= grant1;
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, reset/wrap sequences, randomized run against a reference model.
module tb_alu_arbiter;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]        req0_sel, req1_sel;
    logic              req0_ext, req1_ext;
    logic              resp0_valid, resp1_valid;
    logic              resp0_ready, resp1_ready;
    logic [DATA_W-1:0] resp0_y, resp1_y;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic [2:0]        alu_sel;
    logic              alu_ext;
    logic [CNT_W-1:0]  op_count;

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_ext(req0_ext),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_ext(req1_ext),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_ext(alu_ext), .alu_y(alu_y),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32I ALU behaviour, sel = funct3 encoding.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] sel, input logic ext);
        case (sel)
            3'd0: return ext ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return ext ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_y = alu_ref(alu_a, alu_b, alu_sel, alu_ext);

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [2:0]  s0;
        logic        e0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [2:0]  s1;
        logic        e1;
        logic        rr0, rr1;
        logic        g0, g1;
        logic        rv0;
        logic [31:0] y0;
        logic        rv1;
        logic [31:0] y1;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input int v0, input int a0, input int b0, input int s0, input int e0,
                                input int v1, input int a1, input int b1, input int s1, input int e1,
                                input int rr0, input int rr1, input int g0, input int g1,
                                input int rv0, input int y0, input int rv1, input int y1, input int cnt);
        vec_t r;
        r.v0 = v0[0]; r.a0 = a0; r.b0 = b0; r.s0 = s0[2:0]; r.e0 = e0[0];
        r.v1 = v1[0]; r.a1 = a1; r.b1 = b1; r.s1 = s1[2:0]; r.e1 = e1[0];
        r.rr0 = rr0[0]; r.rr1 = rr1[0]; r.g0 = g0[0]; r.g1 = g1[0];
        r.rv0 = rv0[0]; r.y0 = y0; r.rv1 = rv1[0]; r.y1 = y1; r.cnt = cnt[15:0];
        return r;
    endfunction

    task automatic drive_req(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                             input logic [2:0] s0, input logic e0,
                             input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                             input logic [2:0] s1, input logic e1, input logic rr0, input logic rr1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0; req0_ext = e0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1; req1_ext = e1;
        resp0_ready = rr0; resp1_ready = rr1;
    endtask

    // Reference model state
    int          m_last;
    logic        m_v [2];
    logic [31:0] m_y [2];
    int          m_cnt;
    logic        pv [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [2:0]  ps [2];
    logic        pe [2];
    logic        rr [2];

    task automatic reset_dut();
        drive_req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = 1; m_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            m_v[p] = 1'b0; m_y[p] = '0; pv[p] = 1'b0; rr[p] = 1'b1;
        end
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = mk(1, 5, 7, 0, 0,                  0, 0, 0, 0, 0,         1, 1, 1, 0, 1, 12, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0,                  1, 3, 4, 0, 0,         1, 1, 0, 1, 0, 12, 1, 7, 2);
        tbl[2]  = mk(1, 10, 3, 0, 1,                 1, 'hF0, 'h0F, 4, 0,   1, 1, 1, 0, 1, 7, 0, 7, 3);
        tbl[3]  = mk(1, 10, 3, 0, 1,                 1, 'hF0, 'h0F, 4, 0,   1, 1, 0, 1, 0, 7, 1, 'hFF, 4);
        tbl[4]  = mk(1, 10, 3, 0, 1,                 1, 'hF0, 'h0F, 4, 0,   1, 1, 1, 0, 1, 7, 0, 'hFF, 5);
        tbl[5]  = mk(1, 10, 3, 0, 1,                 1, 'hF0, 'h0F, 4, 0,   1, 1, 0, 1, 0, 7, 1, 'hFF, 6);
        tbl[6]  = mk(0, 0, 0, 0, 0,                  1, 1, 2, 3, 0,         1, 1, 0, 1, 0, 7, 1, 1, 7);
        tbl[7]  = mk(1, 'h100, 'h23, 6, 0,           1, 1, 2, 3, 0,         1, 0, 1, 0, 1, 'h123, 1, 1, 8);
        tbl[8]  = mk(1, 'hFF, 'h0F, 4, 0,            1, 1, 2, 3, 0,         1, 0, 1, 0, 1, 'hF0, 1, 1, 9);
        tbl[9]  = mk(1, 'hFF, 'h0F, 4, 0,            1, 1, 2, 3, 0,         1, 1, 0, 1, 0, 'hF0, 1, 1, 10);
        tbl[10] = mk(1, 1, 1, 0, 0,                  0, 0, 0, 0, 0,         1, 1, 1, 0, 1, 2, 0, 1, 11);
        tbl[11] = mk(1, 32'h80000000, 4, 5, 1,       0, 0, 0, 0, 0,         1, 1, 1, 0, 1, 32'hF8000000, 0, 1, 12);

        // Reset state
        drive_req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp0_valid", 32'(resp0_valid), 0);
        chk("rst_resp1_valid", 32'(resp1_valid), 0);
        chk("rst_resp0_y", resp0_y, 0);
        chk("rst_resp1_y", resp1_y, 0);
        chk("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ea, eb;
            logic [2:0]  es;
            logic        ee;
            drive_req(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].s0, tbl[i].e0,
                      tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].s1, tbl[i].e1, tbl[i].rr0, tbl[i].rr1);
            ea = tbl[i].g0 ? tbl[i].a0 : (tbl[i].g1 ? tbl[i].a1 : 32'd0);
            eb = tbl[i].g0 ? tbl[i].b0 : (tbl[i].g1 ? tbl[i].b1 : 32'd0);
            es = tbl[i].g0 ? tbl[i].s0 : (tbl[i].g1 ? tbl[i].s1 : 3'd0);
            ee = tbl[i].g0 ? tbl[i].e0 : (tbl[i].g1 ? tbl[i].e1 : 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_req0_ready", i), 32'(req0_ready), 32'(tbl[i].g0));
            chk($sformatf("vec%0d_req1_ready", i), 32'(req1_ready), 32'(tbl[i].g1));
            chk($sformatf("vec%0d_alu_a", i), alu_a, ea);
            chk($sformatf("vec%0d_alu_b", i), alu_b, eb);
            chk($sformatf("vec%0d_alu_sel", i), 32'(alu_sel), 32'(es));
            chk($sformatf("vec%0d_alu_ext", i), 32'(alu_ext), 32'(ee));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_resp0_valid", i), 32'(resp0_valid), 32'(tbl[i].rv0));
            chk($sformatf("vec%0d_resp0_y", i), resp0_y, tbl[i].y0);
            chk($sformatf("vec%0d_resp1_valid", i), 32'(resp1_valid), 32'(tbl[i].rv1));
            chk($sformatf("vec%0d_resp1_y", i), resp1_y, tbl[i].y1);
            chk($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(tbl[i].cnt));
        end

        // Fill both buffers, leaving the pointer favouring port 1, then reset mid-flight
        drive_req(1, 1, 1, 0, 0, 1, 2, 3, 0, 0, 0, 0);
        @(negedge clk);
        chk("fill_a_req1_ready", 32'(req1_ready), 1);
        @(posedge clk); #1;
        drive_req(1, 4, 4, 0, 0, 1, 2, 3, 0, 0, 1, 0);
        @(negedge clk);
        chk("fill_b_req0_ready", 32'(req0_ready), 1);
        @(posedge clk); #1;
        chk("fill_resp0_y", resp0_y, 8);
        chk("fill_resp1_y", resp1_y, 5);
        drive_req(1, 4, 4, 0, 0, 1, 2, 3, 0, 0, 1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("inrst_req0_ready", 32'(req0_ready), 0);
        chk("inrst_req1_ready", 32'(req1_ready), 0);
        chk("inrst_alu_a", alu_a, 0);
        chk("inrst_alu_b", alu_b, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("postrst_resp0_valid", 32'(resp0_valid), 0);
        chk("postrst_resp1_valid", 32'(resp1_valid), 0);
        chk("postrst_resp0_y", resp0_y, 0);
        chk("postrst_resp1_y", resp1_y, 0);
        chk("postrst_op_count", 32'(op_count), 0);
        @(negedge clk);
        chk("postrst_first_grant0", 32'(req0_ready), 1);
        chk("postrst_first_grant1", 32'(req1_ready), 0);

        // Randomized run against the reference model
        reset_dut();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic elig [2];
            logic gnt [2];
            int   winner;
            for (int p = 0; p < 2; p++) begin
                if (!pv[p]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pv[p] = 1'b1;
                        pa[p] = $urandom();
                        pb[p] = ($urandom_range(1, 0) == 1) ? $urandom() : 32'($urandom_range(31, 0));
                        ps[p] = 3'($urandom_range(7, 0));
                        pe[p] = 1'($urandom_range(1, 0));
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    pv[p] = 1'b0;
                end
                rr[p] = ($urandom_range(3, 0) != 0);
            end
            drive_req(pv[0], pa[0], pb[0], ps[0], pe[0], pv[1], pa[1], pb[1], ps[1], pe[1], rr[0], rr[1]);

            @(negedge clk);
            chk("rnd_resp0_valid", 32'(resp0_valid), 32'(m_v[0]));
            chk("rnd_resp1_valid", 32'(resp1_valid), 32'(m_v[1]));
            if (m_v[0]) chk("rnd_resp0_y", resp0_y, m_y[0]);
            if (m_v[1]) chk("rnd_resp1_y", resp1_y, m_y[1]);
            chk("rnd_op_count", 32'(op_count), 32'(m_cnt % 65536));

            for (int p = 0; p < 2; p++) elig[p] = pv[p] && (!m_v[p] || rr[p]);
            winner = -1;
            if (elig[0] && elig[1]) winner = 1 - m_last;
            else if (elig[0])       winner = 0;
            else if (elig[1])       winner = 1;
            gnt[0] = (winner == 0);
            gnt[1] = (winner == 1);

            chk("rnd_req0_ready", 32'(req0_ready), 32'(gnt[0]));
            chk("rnd_req1_ready", 32'(req1_ready), 32'(gnt[1]));
            if (winner >= 0) begin
                chk("rnd_alu_a", alu_a, pa[winner]);
                chk("rnd_alu_b", alu_b, pb[winner]);
                chk("rnd_alu_op", {alu_sel, alu_ext}, {ps[winner], pe[winner]});
            end else begin
                chk("rnd_alu_idle", {alu_a | alu_b, alu_sel, alu_ext}, 0);
            end

            for (int p = 0; p < 2; p++) begin
                if (gnt[p]) begin
                    m_v[p] = 1'b1;
                    m_y[p] = alu_ref(pa[p], pb[p], ps[p], pe[p]);
                end else if (rr[p]) begin
                    m_v[p] = 1'b0;
                end
            end
            if (winner >= 0) begin
                m_last = winner;
                m_cnt++;
                pv[winner] = 1'b0;
            end
            @(posedge clk); #1;
        end

        // Counter wrap
        reset_dut();
        drive_req(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_op_count_max", 32'(op_count), 32'hFFFF);
        @(posedge clk); #1;
        chk("wrap_op_count_zero", 32'(op_count), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` instance of the RV32I core between two requesters: port 0, the execute stage, and port 1, the address/compare unit. Each cycle the block picks at most one requester by round-robin and drives the ALU with that requester's operands. It captures `Y` into a one-entry per-requester result buffer, and the requester drains the buffer through a valid/ready handshake. It sits between the requesters and the `A`/`B`/`sel`/`ext`/`Y` pins of `alu`.

## Interface
- `DATA_W`, 32, operand/result width; must match `alu`.
- `CNT_W`, 16, width of the completed-operation counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  each  operation request.
- `req0_ready`, `req1_ready`  out  1  each  request accepted this cycle (grant).
- `req0_a`/`req0_b`, `req1_a`/`req1_b`  in  DATA_W each  operands.
- `req0_sel`, `req1_sel`  in  3 each  ALU function; same encoding as `alu` `sel`.
- `req0_ext`, `req1_ext`  in  1 each  SUB/SRA select; same as `alu` `ext`.
- `resp0_valid`, `resp1_valid`  out  1 each  result buffer full.
- `resp0_ready`, `resp1_ready`  in  1 each  requester consumes result.
- `resp0_y`, `resp1_y`  out  DATA_W each  buffered result.
- `alu_a`, `alu_b`  out  DATA_W  to `alu` `A`, `B`.
- `alu_sel`  out  3  to `alu` `sel`.
- `alu_ext`  out  1  to `alu` `ext`.
- `alu_y`  in  DATA_W  from `alu` `Y` (combinational).
- `op_count`  out  CNT_W  number of granted operations, wraps.

## Operation
- Eligibility: requester N is eligible when `reqN_valid=1` and the buffer can take a result. The buffer can take a result when `respN_valid=0`, or when `respN_valid=1` and `respN_ready=1` (drain and refill in the same cycle).
- Arbitration: a `last` pointer is reset to 1, so port 0 wins first.
  - Both ports eligible: grant the port ≠ `last`.
  - One port eligible: grant that port.
  - `last` updates to the granted port on every grant.
  - At most one grant per cycle.
- `reqN_ready` = grantN. It is combinational from valids, buffer state and `respN_ready`. Requesters must not make `reqN_valid` depend on `reqN_ready`.
- A requester holds `reqN_valid` and its operands stable until accepted. Dropping valid before acceptance is permitted; the request is then simply not performed.
- ALU drive:
  - On a grant, `alu_a`, `alu_b`, `alu_sel` and `alu_ext` equal the granted port's fields in the same cycle (combinational mux).
  - With no grant, the ALU inputs are all zero (ADD 0+0).
- Capture: at the edge ending a grant cycle, `respN_y ← alu_y` and `respN_valid ← 1`.
- Drain: a cycle with `respN_valid=1 && respN_ready=1` and no refill clears `respN_valid`. `respN_y` holds its last value.
- Full-and-stalled buffer (`respN_valid=1`, `respN_ready=0`): port N is ineligible and the other port may be granted every cycle.
- `op_count` increments by 1 per grant and wraps from 2^CNT_W−1 to 0.
- The block performs no arithmetic on data; width and semantics of results are exactly those of `alu`.

## Timing
- Reset (`rst_n=0` at an edge), regardless of in-flight state:
  - `resp0_valid`, `resp1_valid` = 0; `resp0_y`, `resp1_y` = 0; `op_count` = 0; `last` = 1.
  - Buffered results are discarded.
  - `req*_ready` = 0 and the ALU inputs = 0 while `rst_n=0`.
- Latency: request accepted in cycle T → `respN_valid=1` with its result in cycle T+1.
- Throughput: one operation per cycle total. One operation per cycle per port if its consumer holds `respN_ready=1`.
- Continuous requests on both ports: grants alternate 0,1,0,1,…
- Refill cycle: `respN_valid` stays 1 and `respN_y` changes to the new result at the next edge, with no bubble.

## Test plan
- Reset, then `req0` ADD with a=5, b=7, sel=0, ext=0 → `req0_ready=1` in the same cycle, ALU inputs = 5/7/0/0. Next cycle `resp0_valid=1`, `resp0_y=12`, `op_count=1`.
- Both ports valid for 4 cycles (port 0: a=10, b=3, sel=0, ext=1; port 1: a=0xF0, b=0x0F, sel=4) → grants 0,1,0,1. `resp0_y=7`, `resp1_y=0xFF`. `resp*_ready` held 1; `op_count=4`.
- `resp1_ready=0`, `req1` SLTU with a=1, b=2 issued twice while `req0` is also valid:
  - First SLTU granted; `resp1_y=1`.
  - Second SLTU stalls (`req1_ready=0`) while port 0 is granted every cycle.
  - Raising `resp1_ready` → second SLTU is granted the same cycle.
- `resp0_valid=1`, `resp0_ready=1` and a new `req0` (SRA, a=0x80000000, b=4, ext=1) in the same cycle → no bubble, `resp0_valid` stays 1. `resp0_y` becomes the `alu` result at the next edge.
- `rst_n=0` for one edge with both buffers full and both requests valid → next cycle both `resp*_valid=0`, `resp*_y=0`, `op_count=0`. The first grant after reset goes to port 0.
- `op_count` preloaded by 0xFFFF grants, then one more grant → `op_count=0`.
